// File: rtl/job_initiator_pkg.sv
// Shared types and default parameters for the job_initiator block.
// State encoding is fixed so it can be observed from a debug bus.
package job_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/job_initiator_fifo.sv
// job_fifo: operand queue with extra-MSB pointers so full and empty differ.
// Push is dropped when full; pop is dropped when empty.
module job_fifo
    import job_initiator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_push;
    logic              w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/job_initiator.sv
// job_initiator: queues operands and runs one start/done handshake per job.
// Optional WAIT abort counter: define JOB_INITIATOR_TIMEOUT_EN.
module job_initiator
    import job_initiator_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              core_start,
    output logic [DATA_W-1:0] core_data,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy
);

    state_t            r_state;
    state_t            w_next;
    logic              w_pop;
    logic              w_capture;
    logic              w_expire;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              r_core_start;
    logic [DATA_W-1:0] r_core_data;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    job_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef JOB_INITIATOR_TIMEOUT_EN
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT - 1);

    logic [TCW-1:0] r_tcnt;
    logic           r_out_err;

    // A done in the expiring cycle takes priority over the abort.
    assign w_expire = (r_state == ST_WAIT) && !core_done &&
                      (r_tcnt == TC_LAST);

    always_ff @(posedge clk) begin
        if (!rst || r_state != ST_WAIT || core_done)
            r_tcnt <= '0;
        else
            r_tcnt <= r_tcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst)           r_out_err <= 1'b0;
        else if (w_capture) r_out_err <= 1'b0;
        else if (w_expire)  r_out_err <= 1'b1;
    end

    assign out_err = r_out_err;
`else
    assign w_expire = 1'b0;
    assign out_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: w_next = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    w_capture = 1'b1;
                    w_next    = ST_HOLD;
                end else if (w_expire) begin
                    w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_core_start <= 1'b0;
            r_core_data  <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_core_start <= w_pop;
            r_out_valid  <= (w_next == ST_HOLD);
            if (w_pop)          r_core_data <= w_head;
            if (w_capture)      r_out_data  <= core_result;
            else if (w_expire)  r_out_data  <= '0;
        end
    end

    assign core_start = r_core_start;
    assign core_data  = r_core_data;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign in_ready   = !w_full;
    assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_job_initiator.sv
// Bench for job_initiator: directed phases plus a random phase, all
// checked against a queue-based job/result scoreboard.
module tb_job_initiator;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          core_start;
    logic [DW-1:0] core_data;
    logic          core_done = 1'b0;
    logic [DW-1:0] core_result = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic          busy;

    always #5 clk = ~clk;

    job_initiator #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW:0]   res_q [$];
    logic [DW-1:0] cur;
    bit  job_active = 0, in_wait = 0, just_l = 0, ov_prev = 0;
    bit  hang = 0, spur_en = 0;
    int  cd = 0, fix_dly = 0, rdy_mode = 1;
    int  start_cyc = 0, ov_rise = 0, n_done = 0, n_starts = 0;
    int  t_push = 0;

    function automatic logic [DW-1:0] fres(logic [DW-1:0] x);
        return x ^ 8'h7F;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit acc_in, acc_out, in_rst;
        in_rst  = !rst;
        acc_in  = rst && in_valid && in_ready;
        acc_out = rst && out_valid && out_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (in_rst) begin
            exp_q.delete();
            res_q.delete();
            job_active = 0;
            in_wait = 0;
            just_l = 0;
            ov_prev = 0;
            core_done = 1'b0;
            in_valid = 1'b0;
            return;
        end
        if (acc_in) begin
            exp_q.push_back(in_data);
            in_valid = 1'b0;
        end
        if (acc_out) begin
            void'(res_q.pop_front());
            job_active = 0;
            n_done++;
        end
        just_l = 0;
        if (core_start) begin
            n_starts++;
            check("start_while_busy", 32'(job_active), 0);
            check("start_without_job", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("launch_data", core_data, exp_q[0]);
                cur = exp_q.pop_front();
            end
            job_active = 1;
            in_wait = 1;
            just_l = 1;
            start_cyc = cyc;
            cd = (fix_dly != 0) ? fix_dly : $urandom_range(1, 6);
        end
        if (out_valid && !ov_prev) ov_rise = cyc;
        ov_prev = out_valid;
        check("in_ready", in_ready, 32'(exp_q.size() < DEPTH));
        check("busy", busy, 32'(job_active || exp_q.size() != 0));
        check("out_valid", out_valid, 32'(res_q.size() != 0));
        if (out_valid && res_q.size() != 0) begin
            check("out_data", out_data, res_q[0][DW-1:0]);
            check("out_err", out_err, res_q[0][DW]);
        end
        if (in_wait) check("core_data_hold", core_data, cur);
        core_done = 1'b0;
        if (in_wait && !just_l) begin
            if (hang) begin
`ifdef JOB_INITIATOR_TIMEOUT_EN
                if (cyc - start_cyc == TO) begin
                    res_q.push_back({1'b1, 8'h00});
                    in_wait = 0;
                end
`endif
            end else begin
                cd--;
                if (cd == 0) begin
                    core_done = 1'b1;
                    core_result = fres(cur);
                    res_q.push_back({1'b0, fres(cur)});
                    in_wait = 0;
                end
            end
        end else if (spur_en) begin
            core_done = just_l ? 1'b1 : 1'($urandom_range(0, 1));
            core_result = 8'($urandom);
        end
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic push(logic [DW-1:0] d);
        int k;
        in_valid = 1'b1;
        in_data = d;
        k = 0;
        while (in_valid && k < 40) begin
            tick();
            k++;
        end
        if (in_valid) begin
            check("push_accept", 32'(in_valid), 0);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || job_active || res_q.size() != 0 ||
                in_valid) && k < budget) begin
            tick();
            k++;
        end
        check("drain_in_time", 32'(k < budget), 1);
    endtask

    task automatic check_reset_outs(string tag);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_data"}, core_data, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_err"}, out_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int k;
        bit got;
        repeat (3) tick();
        check_reset_outs("rst");
        rst = 1'b1;
        tick();

        // single job: 2A -> 55
        rdy_mode = 1;
        fix_dly = 5;
        in_data = 8'h2A;
        in_valid = 1'b1;
        tick();
        t_push = cyc - 1;
        got = 0;
        k = 0;
        while (!got && k < 10) begin
            tick();
            if (core_start) got = 1;
            k++;
        end
        check("single_start_seen", 32'(got), 1);
        check("single_start_lat", start_cyc - t_push, 2);
        drain(40);
        check("single_done", n_done, 1);
        check("single_starts", n_starts, 1);
        check("single_result_lat", ov_rise - start_cyc, 6);

        // fill queue under backpressure
        rdy_mode = 0;
        fix_dly = 1;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        check("fill_full", in_ready, 0);
        in_data = 8'h15;
        in_valid = 1'b1;
        repeat (10) tick();
        check("fill_blocked", in_ready, 0);
        check("hold_no_restart", n_starts, 2);
        check("hold_valid", out_valid, 1);
        rdy_mode = 1;
        drain(100);
        check("fill_done", n_done, 7);

        // spurious done in IDLE and LAUNCH
        spur_en = 1;
        fix_dly = 3;
        repeat (5) tick();
        check("spur_idle_no_valid", out_valid, 0);
        push(8'h77);
        drain(40);
        check("spur_done", n_done, 8);

        // random traffic
        rdy_mode = 2;
        fix_dly = 0;
        for (int i = 0; i < 30; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        drain(3000);
        check("random_done", n_done, 38);
        rdy_mode = 1;
        spur_en = 0;

        // core never answers
        hang = 1;
        push(8'hC3);
`ifdef JOB_INITIATOR_TIMEOUT_EN
        drain(200);
        check("timeout_done", n_done, 39);
        check("timeout_lat", ov_rise - start_cyc, TO + 1);
`else
        repeat (TO + 36) tick();
        check("wait_persist", out_valid, 0);
        check("wait_busy", busy, 1);
`endif

        // reset with jobs pending
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        repeat (3) tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        tick();
        check_reset_outs("midrst");
        rst = 1'b1;
        hang = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_start_after_rst", core_start, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
